// File: rtl/fft_wr_mux_pkg.sv
// Shared state type and helpers for the FFT write-side bank mux.
package fft_wr_mux_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_FREE = 2'd2
  } state_t;

  localparam int MAX_PORTS = 32;

  function automatic int unsigned popcount(input logic [MAX_PORTS-1:0] vec);
    int unsigned cnt;
    cnt = 32'd0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      cnt += {31'd0, vec[i]};
    end
    return cnt;
  endfunction

  // Explicit wrap keeps the rotation correct for non-power-of-two bank counts.
  function automatic int unsigned bankInc(input int unsigned idx, input int unsigned numBanks);
    return (idx == numBanks - 32'd1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/fft_wr_mux_bank_tracker.sv
// Bank ownership flags: set when a stage completes, cleared by reader release.
module fft_bank_tracker
  import fft_wr_mux_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_setEn,
  input  logic [BANK_W-1:0]    i_setIdx,
  input  logic [NUM_BANKS-1:0] i_release,
  input  logic [BANK_W-1:0]    i_curIdx,
  input  logic [BANK_W-1:0]    i_nextIdx,
  output logic [NUM_BANKS-1:0] o_bankFull,
  output logic                 o_curFull,
  output logic                 o_nextFree
);

  logic [NUM_BANKS-1:0] r_full;
  logic [NUM_BANKS-1:0] w_fullNext;

  // Release is applied first so a same-cycle set on that bank wins.
  always_comb begin
    w_fullNext = r_full;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (i_release[b]) w_fullNext[b] = 1'b0;
      if (i_setEn && (i_setIdx == BANK_W'(b))) w_fullNext[b] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_full <= '0;
    else        r_full <= w_fullNext;
  end

  assign o_bankFull = r_full;
  assign o_curFull  = r_full[i_curIdx];
  assign o_nextFree = ~r_full[i_nextIdx];

endmodule

// File: rtl/fft_wr_mux.sv
// Write-side FFT memory mux: rotates stages across banks and stalls on owned banks.
// Optional FFT_WR_MUX_COLLISION_CHK_EN: same-address port collisions keep the lowest port.
module fft_wr_mux
  import fft_wr_mux_pkg::*;
#(
  parameter int FFT_SIZE     = 4096,
  parameter int SAMPLE_WIDTH = 16,
  parameter int ADDR_WIDTH   = $clog2(FFT_SIZE),
  parameter int DATA_WIDTH   = 2 * SAMPLE_WIDTH,
  parameter int NUM_PORTS    = 2,
  parameter int NUM_BANKS    = 2,
  parameter int BANK_W       = $clog2(NUM_BANKS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] fft_waddr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] fft_wdata,
  input  logic [NUM_PORTS-1:0]            fft_we,
  output logic                            in_ready,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0] mem_waddr,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] mem_wdata,
  output logic [NUM_BANKS*NUM_PORTS-1:0]  mem_we,
  output logic [BANK_W-1:0]               wmem_id,
  output logic [NUM_BANKS-1:0]            bank_full,
  input  logic [NUM_BANKS-1:0]            bank_release,
  output logic                            stage_done,
  output logic                            collision_err
);

  state_t                          r_state, w_nextState;
  logic [ADDR_WIDTH:0]             r_wrCnt;
  logic [BANK_W-1:0]               r_wmemId, w_nextId;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] r_memWaddr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] r_memWdata;
  logic [NUM_BANKS*NUM_PORTS-1:0]  r_memWe, w_weDecode;
  logic                            r_stageDone;
  logic [NUM_PORTS-1:0]            w_accept, w_fwd;
  logic [ADDR_WIDTH+1:0]           w_sum;
  logic                            w_stageEnd, w_curFull, w_nextFree;

  assign in_ready = (r_state == WRITE);
  assign w_accept = fft_we & {NUM_PORTS{in_ready}};
  assign w_sum    = {1'b0, r_wrCnt} + (ADDR_WIDTH+2)'(popcount(MAX_PORTS'(w_accept)));
  assign w_stageEnd = in_ready && (w_sum >= (ADDR_WIDTH+2)'(FFT_SIZE));
  assign w_nextId = BANK_W'(bankInc(32'(r_wmemId), NUM_BANKS));

`ifdef FFT_WR_MUX_COLLISION_CHK_EN
  logic r_colErr;
  logic w_colHit;

  // Suppressed ports still count toward the stage total; only their enable is dropped.
  always_comb begin
    w_fwd    = w_accept;
    w_colHit = 1'b0;
    for (int q = 1; q < NUM_PORTS; q++) begin
      for (int p = 0; p < q; p++) begin
        if (w_accept[p] && w_accept[q] &&
            (fft_waddr[p*ADDR_WIDTH +: ADDR_WIDTH] == fft_waddr[q*ADDR_WIDTH +: ADDR_WIDTH])) begin
          w_fwd[q] = 1'b0;
          w_colHit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        r_colErr <= 1'b0;
    else if (w_colHit) r_colErr <= 1'b1;
  end

  assign collision_err = r_colErr;
`else
  assign w_fwd         = w_accept;
  assign collision_err = 1'b0;
`endif

  always_comb begin
    w_weDecode = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (r_wmemId == BANK_W'(b)) w_weDecode[b*NUM_PORTS +: NUM_PORTS] = w_fwd;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:      if (start) w_nextState = w_curFull ? WAIT_FREE : WRITE;
      WRITE:     if (w_stageEnd) w_nextState = w_nextFree ? WRITE : WAIT_FREE;
      WAIT_FREE: if (!w_curFull) w_nextState = WRITE;
      default:   w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wrCnt     <= '0;
      r_wmemId    <= '0;
      r_memWaddr  <= '0;
      r_memWdata  <= '0;
      r_memWe     <= '0;
      r_stageDone <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_memWe     <= w_weDecode;
      r_stageDone <= w_stageEnd;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_accept[p]) begin
          r_memWaddr[p*ADDR_WIDTH +: ADDR_WIDTH] <= fft_waddr[p*ADDR_WIDTH +: ADDR_WIDTH];
          r_memWdata[p*DATA_WIDTH +: DATA_WIDTH] <= fft_wdata[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (w_stageEnd) begin
        r_wrCnt  <= '0;
        r_wmemId <= w_nextId;
      end else begin
        r_wrCnt  <= w_sum[ADDR_WIDTH:0];
      end
    end
  end

  fft_bank_tracker #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W)
  ) u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_setEn    (w_stageEnd),
    .i_setIdx   (r_wmemId),
    .i_release  (bank_release),
    .i_curIdx   (r_wmemId),
    .i_nextIdx  (w_nextId),
    .o_bankFull (bank_full),
    .o_curFull  (w_curFull),
    .o_nextFree (w_nextFree)
  );

  assign mem_waddr  = r_memWaddr;
  assign mem_wdata  = r_memWdata;
  assign mem_we     = r_memWe;
  assign wmem_id    = r_wmemId;
  assign stage_done = r_stageDone;

endmodule

// File: tb/tb_fft_wr_mux.sv
// Bench for fft_wr_mux: directed table, corner sequences, and random traffic against a model.
module tb_fft_wr_mux;
  localparam int N  = 16;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NP = 2;
  localparam int NB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstA, startA, rstB, startB;
  logic [NP*AW-1:0]  waddr;
  logic [NP*DW-1:0]  wdata;
  logic [NP-1:0]     we;
  logic [NB-1:0]     relA;
  logic [2:0]        relB;

  logic              readyA, doneA, errA;
  logic [NP*AW-1:0]  memWaddrA;
  logic [NP*DW-1:0]  memWdataA;
  logic [NB*NP-1:0]  memWeA;
  logic [0:0]        wmemA;
  logic [NB-1:0]     fullA;

  logic              readyB, doneB, errB;
  logic [NP*AW-1:0]  memWaddrB;
  logic [NP*DW-1:0]  memWdataB;
  logic [3*NP-1:0]   memWeB;
  logic [1:0]        wmemB;
  logic [2:0]        fullB;

  fft_wr_mux #(.FFT_SIZE(N), .SAMPLE_WIDTH(16), .NUM_PORTS(NP), .NUM_BANKS(NB)) dutA (
    .clk(clk), .rst_n(rstA), .start(startA), .fft_waddr(waddr), .fft_wdata(wdata),
    .fft_we(we), .in_ready(readyA), .mem_waddr(memWaddrA), .mem_wdata(memWdataA),
    .mem_we(memWeA), .wmem_id(wmemA), .bank_full(fullA), .bank_release(relA),
    .stage_done(doneA), .collision_err(errA)
  );

  fft_wr_mux #(.FFT_SIZE(N), .SAMPLE_WIDTH(16), .NUM_PORTS(NP), .NUM_BANKS(3)) dutB (
    .clk(clk), .rst_n(rstB), .start(startB), .fft_waddr(waddr), .fft_wdata(wdata),
    .fft_we(we), .in_ready(readyB), .mem_waddr(memWaddrB), .mem_wdata(memWdataB),
    .mem_we(memWeB), .wmem_id(wmemB), .bank_full(fullB), .bank_release(relB),
    .stage_done(doneB), .collision_err(errB)
  );

  int nChecks = 0;
  int nFails  = 0;

  // Behavioural model: mode 0 idle, 1 writing, 2 waiting for a free bank.
  int               mMode, mCnt, mBank;
  logic [NB-1:0]    mFull;
  logic             mErr, eDone;
  logic [NB*NP-1:0] eWe;
  logic [NP*AW-1:0] eWaddr;
  logic [NP*DW-1:0] eWdata;

  typedef struct {
    logic       start;
    logic [1:0] we;
    logic [1:0] rel;
    logic       expReady;
    logic [3:0] expWe;
    logic       expDone;
    logic       expWmem;
    logic [1:0] expFull;
  } vec_t;

  vec_t vecs [21];

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic modelStep(input logic s, input logic [NP-1:0] w, input logic [NP*AW-1:0] a,
                           input logic [NP*DW-1:0] d, input logic [NB-1:0] r, input logic rn);
    logic [NP-1:0] acc, fwd;
    logic [NB-1:0] oldFull;
    logic          done;
    int            n;
    if (!rn) begin
      mMode = 0; mCnt = 0; mBank = 0; mFull = '0; mErr = 1'b0;
      eWe = '0; eWaddr = '0; eWdata = '0; eDone = 1'b0;
      return;
    end
    acc = (mMode == 1) ? w : '0;
    fwd = acc;
`ifdef FFT_WR_MUX_COLLISION_CHK_EN
    if (acc == 2'b11 && a[AW-1:0] == a[2*AW-1:AW]) begin
      fwd  = 2'b01;
      mErr = 1'b1;
    end
`endif
    n = $countones(acc);
    eWe = {{(NB*NP-NP){1'b0}}, fwd} << (mBank * NP);
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) begin
        eWaddr[p*AW +: AW] = a[p*AW +: AW];
        eWdata[p*DW +: DW] = d[p*DW +: DW];
      end
    end
    done = (mMode == 1) && (mCnt + n >= N);
    oldFull = mFull;
    for (int b = 0; b < NB; b++) if (r[b]) mFull[b] = 1'b0;
    if (done) mFull[mBank] = 1'b1;
    case (mMode)
      0: if (s) mMode = oldFull[mBank] ? 2 : 1;
      1: if (done) begin
           mBank = (mBank + 1) % NB;
           mCnt  = 0;
           mMode = oldFull[mBank] ? 2 : 1;
         end else mCnt += n;
      default: if (!oldFull[mBank]) mMode = 1;
    endcase
    eDone = done;
  endtask

  task automatic applyStimulus(input logic s, input logic [NP-1:0] w, input logic [NP*AW-1:0] a,
                               input logic [NP*DW-1:0] d, input logic [NB-1:0] r, input logic rn);
    startA = s; we = w; waddr = a; wdata = d; relA = r; rstA = rn;
    @(posedge clk);
    modelStep(s, w, a, d, r, rn);
    #1;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".in_ready"},   64'(readyA),    64'(mMode == 1));
    checkOutput({tag, ".mem_we"},     64'(memWeA),    64'(eWe));
    checkOutput({tag, ".mem_waddr"},  64'(memWaddrA), 64'(eWaddr));
    checkOutput({tag, ".mem_wdata"},  memWdataA,      eWdata);
    checkOutput({tag, ".wmem_id"},    64'(wmemA),     64'(mBank));
    checkOutput({tag, ".bank_full"},  64'(fullA),     64'(mFull));
    checkOutput({tag, ".stage_done"}, 64'(doneA),     64'(eDone));
    checkOutput({tag, ".coll_err"},   64'(errA),      64'(mErr));
  endtask

  task automatic stepModel(input string tag, input logic s, input logic [NP-1:0] w,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [NB-1:0] r, input logic rn);
    applyStimulus(s, w, {a1, a0}, {$urandom, $urandom}, r, rn);
    checkAll(tag);
  endtask

  task automatic stepB(input logic s, input logic [NP-1:0] w, input logic [AW-1:0] a0,
                       input logic [2:0] r, input logic rn);
    startB = s; we = w; waddr = {a0 + 4'd1, a0}; wdata = {$urandom, $urandom}; relB = r; rstB = rn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] bankSeq [4];
    rstA = 1'b0; startA = 1'b0; rstB = 1'b0; startB = 1'b0;
    we = '0; waddr = '0; wdata = '0; relA = '0; relB = '0;

    // Directed table: two full stages, a dropped write while stalled, then a release.
    vecs[0] = '{1'b1, 2'b00, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b00};
    for (int i = 1; i <= 8; i++)
      vecs[i] = '{1'b0, 2'b11, 2'b00, 1'b1, 4'b0011, (i == 8), (i == 8), (i == 8) ? 2'b01 : 2'b00};
    vecs[9] = '{1'b0, 2'b00, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b1, 2'b01};
    for (int i = 10; i <= 17; i++)
      vecs[i] = '{1'b0, 2'b11, 2'b00, (i != 17), 4'b1100, (i == 17), (i != 17), (i == 17) ? 2'b11 : 2'b01};
    vecs[18] = '{1'b0, 2'b11, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b11};
    vecs[19] = '{1'b0, 2'b00, 2'b01, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b10};
    vecs[20] = '{1'b0, 2'b00, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b10};

    stepModel("reset", 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 1'b0);
    checkOutput("reset.in_ready", 64'(readyA), 64'd0);
    checkOutput("reset.bank_full", 64'(fullA), 64'd0);

    for (int i = 0; i < 21; i++) begin
      logic [NP*AW-1:0] a;
      a = {4'(2 * i + 1), 4'(2 * i)};
      applyStimulus(vecs[i].start, vecs[i].we, a, {$urandom, $urandom}, vecs[i].rel, 1'b1);
      checkOutput($sformatf("vec%0d.in_ready", i),   64'(readyA), 64'(vecs[i].expReady));
      checkOutput($sformatf("vec%0d.mem_we", i),     64'(memWeA), 64'(vecs[i].expWe));
      checkOutput($sformatf("vec%0d.stage_done", i), 64'(doneA),  64'(vecs[i].expDone));
      checkOutput($sformatf("vec%0d.wmem_id", i),    64'(wmemA),  64'(vecs[i].expWmem));
      checkOutput($sformatf("vec%0d.bank_full", i),  64'(fullA),  64'(vecs[i].expFull));
      if (vecs[i].expWe != 4'b0000)
        checkOutput($sformatf("vec%0d.mem_waddr", i), 64'(memWaddrA), 64'(a));
    end

    // Odd counts: fifteen single writes, then a dual write crosses the stage boundary.
    stepModel("odd.rst", 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 1'b0);
    stepModel("odd.start", 1'b1, 2'b00, 4'd0, 4'd0, 2'b00, 1'b1);
    for (int i = 0; i < 15; i++)
      stepModel("odd.single", 1'b0, 2'(1 << (i % 2)), 4'(i), 4'(i), 2'b00, 1'b1);
    stepModel("odd.dual", 1'b0, 2'b11, 4'd14, 4'd15, 2'b00, 1'b1);
    checkOutput("odd.stage_done", 64'(doneA), 64'd1);
    checkOutput("odd.mem_we", 64'(memWeA), 64'b0011);

    // Same-address dual write: collision handling depends on the build option.
    stepModel("col.rst", 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 1'b0);
    stepModel("col.start", 1'b1, 2'b00, 4'd0, 4'd0, 2'b00, 1'b1);
    stepModel("col.hit", 1'b0, 2'b11, 4'd5, 4'd5, 2'b00, 1'b1);
`ifdef FFT_WR_MUX_COLLISION_CHK_EN
    checkOutput("col.mem_we", 64'(memWeA), 64'b0001);
    checkOutput("col.err", 64'(errA), 64'd1);
`else
    checkOutput("col.mem_we", 64'(memWeA), 64'b0011);
    checkOutput("col.err", 64'(errA), 64'd0);
`endif
    for (int i = 0; i < 7; i++)
      stepModel("col.fill", 1'b0, 2'b11, 4'(2 * i), 4'(2 * i + 1), 2'b00, 1'b1);
    checkOutput("col.stage_done", 64'(doneA), 64'd1);
    stepModel("col.hold", 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 1'b1);

    // Reset after five writes, then a fresh stage must start counting from zero.
    stepModel("mid.rst", 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 1'b0);
    stepModel("mid.start", 1'b1, 2'b00, 4'd0, 4'd0, 2'b00, 1'b1);
    for (int i = 0; i < 5; i++)
      stepModel("mid.wr", 1'b0, 2'b01, 4'(i), 4'(i), 2'b00, 1'b1);
    stepModel("mid.reset", 1'b0, 2'b11, 4'd1, 4'd2, 2'b00, 1'b0);
    checkOutput("mid.in_ready", 64'(readyA), 64'd0);
    checkOutput("mid.mem_we", 64'(memWeA), 64'd0);
    checkOutput("mid.mem_waddr", 64'(memWaddrA), 64'd0);
    stepModel("mid.start2", 1'b1, 2'b00, 4'd0, 4'd0, 2'b00, 1'b1);
    for (int i = 0; i < 8; i++)
      stepModel("mid.fill", 1'b0, 2'b11, 4'(2 * i), 4'(2 * i + 1), 2'b00, 1'b1);
    checkOutput("mid.stage_done", 64'(doneA), 64'd1);
    checkOutput("mid.bank_full", 64'(fullA), 64'b01);

    // Random traffic, releases, stray starts and occasional resets against the model.
    stepModel("rnd.rst", 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 1'b0);
    for (int i = 0; i < 600; i++) begin
      logic s, rn;
      logic [NB-1:0] r;
      s  = ($urandom_range(0, 15) == 0) || (i == 0);
      rn = ($urandom_range(0, 199) != 0);
      r  = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      stepModel("rnd", s, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), r, rn);
    end

    // Three-bank rotation with the reader releasing each bank right after it fills.
    rstA = 1'b0;
    bankSeq = '{2'd0, 2'd1, 2'd2, 2'd0};
    stepB(1'b0, 2'b00, 4'd0, 3'b000, 1'b0);
    stepB(1'b1, 2'b00, 4'd0, 3'b000, 1'b1);
    checkOutput("b3.in_ready", 64'(readyB), 64'd1);
    for (int s = 0; s < 4; s++) begin
      checkOutput($sformatf("b3.stage%0d.wmem_id", s), 64'(wmemB), 64'(bankSeq[s]));
      for (int i = 0; i < 8; i++) stepB(1'b0, 2'b11, 4'(2 * i), 3'b000, 1'b1);
      checkOutput($sformatf("b3.stage%0d.done", s), 64'(doneB), 64'd1);
      checkOutput($sformatf("b3.stage%0d.ready", s), 64'(readyB), 64'd1);
      stepB(1'b0, 2'b00, 4'd0, 3'(1 << bankSeq[s]), 1'b1);
    end
    checkOutput("b3.final.wmem_id", 64'(wmemB), 64'd1);
    checkOutput("b3.final.err", 64'(errB), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/fft_wr_mux.md
# fft_wr_mux

Parametrised write-side memory mux for the FFT datapath. It takes NUM_PORTS concurrent FFT write ports and steers each stage's writes into one of NUM_BANKS sample-memory banks in ping-pong rotation. It tracks bank ownership with a fill/release handshake to the reader and stalls the FFT when the next bank is still owned downstream. It sits between the FFT butterfly write-back and the bank RAMs, and replaces the fixed two-port, two-bank write selection.

## Interface
- FFT_SIZE, 4096, points per stage (power of two)
- SAMPLE_WIDTH, 16, width of real/imag part
- ADDR_WIDTH, $clog2(FFT_SIZE), memory address width
- DATA_WIDTH, 2*SAMPLE_WIDTH, complex word width
- NUM_PORTS, 2, concurrent write ports
- NUM_BANKS, 2, memory banks (>=2)
- BANK_W, $clog2(NUM_BANKS), bank index width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  pulse: begin filling current bank
- fft_waddr  in  NUM_PORTS*ADDR_WIDTH  per-port write address
- fft_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data
- fft_we  in  NUM_PORTS  per-port write enable
- in_ready  out  1  writes accepted this cycle
- mem_waddr  out  NUM_PORTS*ADDR_WIDTH  registered address, broadcast to all banks
- mem_wdata  out  NUM_PORTS*DATA_WIDTH  registered data, broadcast
- mem_we  out  NUM_BANKS*NUM_PORTS  per-bank per-port enable
- wmem_id  out  BANK_W  bank currently being written
- bank_full  out  NUM_BANKS  level: bank holds a complete stage
- bank_release  in  NUM_BANKS  pulse: reader done with bank
- stage_done  out  1  one-cycle pulse at stage completion
- collision_err  out  1  sticky same-address collision flag

## Operation
- FSM states: IDLE, WRITE, WAIT_FREE.
- IDLE: in_ready=0. On start, go to WRITE if bank wmem_id is not full; otherwise go to WAIT_FREE.
- WRITE: in_ready=1. A port write is accepted when fft_we[p]=1.
  - On acceptance, register address and data and assert mem_we[wmem_id][p].
  - Write counter (ADDR_WIDTH+1 bits) increments by popcount of accepted enables.
- When counter+popcount >= FFT_SIZE:
  - that cycle's writes are still forwarded
  - counter clears; bank_full[wmem_id] sets
  - stage_done pulses
  - wmem_id advances to (wmem_id+1) mod NUM_BANKS, with explicit wrap at NUM_BANKS-1 for non-power-of-two counts
  - next state is WRITE if the next bank is not full, else WAIT_FREE
- WAIT_FREE: in_ready=0. Exit to WRITE the cycle after bank_full[wmem_id] clears.
- bank_release[i] clears bank_full[i]. A release in the same cycle as that bank's set is ignored: set wins.
- fft_we while in_ready=0 is a protocol violation. Those writes are dropped, nothing is counted, and no mem_we is asserted.
- start outside IDLE is ignored.
- Mid-operation reset returns to IDLE: counter=0, wmem_id=0, bank_full=0.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, wmem_id=0, bank_full=0, stage_done=0, collision_err=0.
- Latency: 1 cycle from fft_we/addr/data to mem_we/mem_waddr/mem_wdata.
- in_ready is registered from state and valid in the cycle it is sampled.
- The first in_ready=1 occurs 1 cycle after start.
- After stage_done, the next stage's writes are accepted:
  - with no gap, if the next bank is free
  - the cycle after the release-driven clear, otherwise
- bank_full rises in the cycle stage_done is high.

## Configuration
- FFT_WR_MUX_COLLISION_CHK_EN defined:
  - if two accepted ports carry equal addresses in one cycle, the lowest-index port wins
  - higher ports' mem_we are suppressed but still counted
  - collision_err sets and holds until reset
- Undefined: all ports are forwarded unchanged and collision_err is tied 0.

## Structure
- Shared package fft_wr_mux_pkg holds:
  - the state enum (IDLE/WRITE/WAIT_FREE)
  - the popcount function
  - the bank-index increment-with-wrap function
- One sub-module, fft_bank_tracker: owns bank_full set/release logic and the free check for the next bank.

## Test plan
- Reset, start, FFT_SIZE=16, 2 ports writing 8 cycles -> 16 writes land in bank 0 with 1-cycle latency; stage_done at the 8th write cycle; wmem_id=1; bank_full=2'b01.
- Two stages without release -> after the second stage_done, bank_full=2'b11, in_ready=0, FSM in WAIT_FREE. bank_release[0] -> in_ready=1 two cycles later, wmem_id=0.
- Single-port writes, odd counts (FFT_SIZE=16, 15 single writes then 1 dual) -> stage_done on the dual-write cycle; both writes are forwarded.
- Equal addresses on both ports with the macro on -> only port 0 mem_we fires; collision_err=1 sticky; count still +2. With the macro off, both fire and err=0.
- NUM_BANKS=3 over three stages with releases -> wmem_id sequence 0,1,2,0.
- rst_n low mid-stage (5 writes done) -> all outputs return to reset values; a new start refills bank 0 from count 0.
